// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default baud divisor and line levels.
// Used by both the TX serializer and the baud generator.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5
    } state_t;

    // 100 MHz system clock / 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    localparam logic FRAME_START = 1'b0;
    localparam logic FRAME_STOP  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Integer baud divider: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// Held at zero while i_clr is high so the first bit period after a clear is full length.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] TERM_CNT = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;
    logic          w_term;

    assign w_term = (r_cnt == TERM_CNT);
    assign o_tick = w_term && !i_clr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || w_term) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// Pops bytes from the TX FIFO and shifts each out as an 8N1 frame on o_tx.
// All outputs are registered; the next-state decision also sets the output values.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int BW           = 8,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    input  logic          i_fifo_empty,
    input  logic [BW-1:0] i_fifo_data,
    output logic          o_fifo_rd,
    output logic          o_tx,
    output logic          o_busy,
    output logic          o_done
);

    localparam int IW = (BW > 1) ? $clog2(BW) : 1;
    localparam logic [IW-1:0] LAST_BIT = IW'(BW - 1);

    state_t        r_state;
    logic [BW-1:0] r_shift;
    logic [IW-1:0] r_bit_idx;
    logic          r_tx;
    logic          r_fifo_rd;
    logic          r_busy;
    logic          r_done;

    logic          w_tick;
    logic          w_baud_clr;
    logic          w_start_ok;
    logic [BW-1:0] w_shift_next;

    // Baud counter only runs while a bit is on the line; LOAD always sees it cleared.
    assign w_baud_clr   = (r_state != ST_START) && (r_state != ST_DATA) && (r_state != ST_STOP);
    assign w_start_ok   = i_en && !i_fifo_empty;
    assign w_shift_next = r_shift >> 1;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_baud_clr),
        .o_tick  (w_tick)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_tx      <= IDLE_LEVEL;
            r_fifo_rd <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_fifo_rd <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_state   <= ST_FETCH;
                        r_fifo_rd <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_shift   <= i_fifo_data;
                    r_bit_idx <= '0;
                    r_tx      <= FRAME_START;
                    r_state   <= ST_START;
                end
                ST_START: begin
                    if (w_tick) begin
                        r_tx    <= r_shift[0];
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx == LAST_BIT) begin
                            r_tx    <= FRAME_STOP;
                            r_state <= ST_STOP;
                        end else begin
                            // o_tx follows the bit that becomes shift[0] after this shift
                            r_shift   <= w_shift_next;
                            r_tx      <= w_shift_next[0];
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        r_done <= 1'b1;
                        if (w_start_ok) begin
                            r_state   <= ST_FETCH;
                            r_fifo_rd <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_tx    <= IDLE_LEVEL;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= IDLE_LEVEL;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_fifo_rd = r_fifo_rd;
    assign o_tx      = r_tx;
    assign o_busy    = r_busy;
    assign o_done    = r_done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer with a 1-cycle-latency FIFO model and a
// byte scoreboard that is decoded against the serial line bit by bit.
module tb_uart_tx_serializer;

    localparam int BW  = 8;
    localparam int CPB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          fifo_empty;
    logic [BW-1:0] fifo_data = '0;
    logic          fifo_rd;
    logic          tx;
    logic          busy;
    logic          done;

    int vectors = 0;
    int errors  = 0;

    logic [BW-1:0] fifo_mem [0:15];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    logic [BW-1:0] exp_q[$];

    int rd_count   = 0;
    int done_count = 0;
    int bad_rd     = 0;

    always #5 clk = ~clk;

    uart_tx_serializer #(
        .BW           (BW),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .i_fifo_empty (fifo_empty),
        .i_fifo_data  (fifo_data),
        .o_fifo_rd    (fifo_rd),
        .o_tx         (tx),
        .o_busy       (busy),
        .o_done       (done)
    );

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd === 1'b1) begin
            fifo_data <= fifo_mem[rd_ptr % 16];
            rd_ptr    <= rd_ptr + 1;
            rd_count  <= rd_count + 1;
        end
        if (done === 1'b1) done_count <= done_count + 1;
    end

    always @(negedge clk) begin
        if (fifo_rd === 1'b1 && fifo_empty) bad_rd <= bad_rd + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [BW-1:0] b, input bit track);
        fifo_mem[wr_ptr % 16] = b;
        wr_ptr++;
        if (track) exp_q.push_back(b);
    endtask

    // Waits for a start bit, then checks every cycle of the frame and the o_done pulse.
    // hi_cycles counts the idle-high samples seen before the start bit.
    task automatic check_frame(input int drop_bit, output int hi_cycles);
        logic [BW-1:0] exp_byte;
        logic [BW+1:0] bits;
        bit            found;
        hi_cycles = 0;
        found     = 0;
        exp_byte  = '0;
        chk("scoreboard_nonempty", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) exp_byte = exp_q.pop_front();
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (tx === 1'b0) found = 1;
            else hi_cycles++;
        end
        chk("start_seen", found, 1);
        if (found) begin
            bits = {1'b1, exp_byte, 1'b0};
            for (int b = 0; b < BW + 2; b++) begin
                for (int c = 0; c < CPB; c++) begin
                    if (b != 0 || c != 0) @(negedge clk);
                    if (b == drop_bit && c == 0) en = 1'b0;
                    chk($sformatf("frame_%02h_bit%0d_cyc%0d", exp_byte, b, c),
                        {29'd0, tx, busy, done}, {29'd0, bits[b], 1'b1, 1'b0});
                end
            end
            @(negedge clk);
            chk($sformatf("done_pulse_%02h", exp_byte), {30'd0, tx, done}, 32'd3);
            $display("frame %02h checked", exp_byte);
        end
    endtask

    initial begin
        int   gap;
        int   rd_before;
        bit   found;

        rst_n = 1'b0;
        en    = 1'b0;

        // 1. reset
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_outputs", {28'd0, tx, fifo_rd, busy, done}, 32'h8);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_reset_idle", {28'd0, tx, fifo_rd, busy, done}, 32'h8);
        end

        // 2. single byte 0xA5
        rd_before = rd_count;
        push_byte(8'hA5, 1);
        en = 1'b1;
        check_frame(-1, gap);
        chk("first_gap_from_idle", gap, 2);
        repeat (5) @(negedge clk);
        chk("a5_rd_pulses", rd_count - rd_before, 1);

        // 3. back-to-back frames
        rd_before = rd_count;
        push_byte(8'h00, 1);
        push_byte(8'hFF, 1);
        push_byte(8'h55, 1);
        check_frame(-1, gap);
        check_frame(-1, gap);
        chk("gap_00_ff", gap + 1, 2);
        check_frame(-1, gap);
        chk("gap_ff_55", gap + 1, 2);
        repeat (5) @(negedge clk);
        chk("b2b_rd_pulses", rd_count - rd_before, 3);

        // 4. empty FIFO with enable high
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("empty_idle", {29'd0, fifo_rd, tx, busy}, 32'h2);
        end

        // 5. drop enable during data bit 3 of the first of two frames
        rd_before = rd_count;
        push_byte(8'hC3, 1);
        push_byte(8'h5A, 1);
        check_frame(4, gap);
        chk("en_drop_busy_cleared", busy, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("en_low_idle", {29'd0, fifo_rd, tx, busy}, 32'h2);
        end
        chk("en_drop_rd_pulses", rd_count - rd_before, 1);
        en = 1'b1;
        check_frame(-1, gap);

        // 6. asynchronous reset in the middle of a data bit
        push_byte(8'h00, 0);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (tx === 1'b0) found = 1;
        end
        chk("abort_start_seen", found, 1);
        repeat (6) @(negedge clk);
        chk("abort_mid_data_low", tx, 0);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_tx_high", {30'd0, tx, busy}, 32'h2);
        @(negedge clk);
        chk("reset_hold", {28'd0, tx, fifo_rd, busy, done}, 32'h8);
        rst_n = 1'b1;
        push_byte(8'h3C, 1);
        check_frame(-1, gap);
        repeat (5) @(negedge clk);

        chk("scoreboard_drained", exp_q.size(), 0);
        chk("rd_while_empty", bad_rd, 0);
        chk("total_rd_pulses", rd_count, 8);
        chk("total_done_pulses", done_count, 7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
